lfsr_checker: RTL
=================

LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_COUNT, default 4: consecutive matching words needed to declare lock (range 1..15).
REQ-002 SHALL have parameter UNLOCK_COUNT, default 3: consecutive mismatching words that drop lock (range 1..15).
REQ-003 SHALL have parameter ERR_W, default 16: width of the error counters.
REQ-004 SHALL have port CLK  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port RESETH  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port IN_VALID  input  1  IN_DATA holds one received LFSR word this cycle.
REQ-007 SHALL have port IN_DATA  input  32  received word; successive valid words are successive LFSR states.
REQ-008 SHALL have port CLR_ERR  input  1  synchronous clear of the error counters.
REQ-009 SHALL have port LOCKED  output  1  high while the checker is in LOCKED.
REQ-010 SHALL have port ERR_PULSE  output  1  one-cycle pulse per mismatching word while locked.
REQ-011 SHALL have port ERR_COUNT  output  ERR_W  saturating count of mismatching words.
REQ-012 SHALL have port BIT_ERR_COUNT  output  ERR_W  saturating count of mismatching bits (see Configuration).

Function
REQ-013 SHALL define next(s) = {s[0]^s[9]^s[29]^s[30], s[31:1]}: right shift, feedback into bit 31.
REQ-014 SHALL implement three states: SEARCH, LOCKING and LOCKED; cycles with IN_VALID=0 change no state, counter or prediction.
REQ-015 In SEARCH, a valid nonzero word SHALL load pred=next(IN_DATA), clear match_cnt and go to LOCKING; a valid all-zero word SHALL leave the checker in SEARCH.
REQ-016 In LOCKING, a valid word equal to pred SHALL increment match_cnt and load pred=next(IN_DATA); when match_cnt reaches LOCK_COUNT the state SHALL become LOCKED.
REQ-017 In LOCKING, a valid mismatching word SHALL reseed per REQ-015 (nonzero: stay in LOCKING with match_cnt=0; zero: go to SEARCH).
REQ-018 In LOCKED, pred SHALL advance as pred=next(pred) on every valid word, independent of IN_DATA (flywheel), so a corrupted word does not corrupt later predictions.
REQ-019 In LOCKED, a mismatching word SHALL raise ERR_PULSE, increment ERR_COUNT and increment miss_cnt; a matching word SHALL clear miss_cnt.
REQ-020 When miss_cnt reaches UNLOCK_COUNT the state SHALL become SEARCH, with miss_cnt cleared.
REQ-021 Outputs SHALL be registered: LOCKED and ERR_PULSE SHALL update in the cycle after the deciding IN_VALID cycle (1-cycle latency).
REQ-022 Errors SHALL be counted only in LOCKED; counters SHALL saturate at all ones and never wrap.
REQ-023 If CLR_ERR coincides with an error, the clear SHALL win (counter ends at 0); ERR_PULSE SHALL still assert.

Reset
REQ-024 RESETH high SHALL force SEARCH, LOCKED=0, ERR_PULSE=0, ERR_COUNT=0, BIT_ERR_COUNT=0, match_cnt=0, miss_cnt=0 and pred=32'hFFFFFFFF on the next clock edge, overriding all other inputs, including mid-lock.

Configuration
REQ-025 With macro LFSR_CHECKER_BITERR_EN defined, each locked mismatch SHALL add popcount(IN_DATA^pred) (1..32) to BIT_ERR_COUNT, saturating, in the same cycle ERR_COUNT updates.
REQ-026 With LFSR_CHECKER_BITERR_EN undefined, BIT_ERR_COUNT SHALL be constant 0 and no popcount logic SHALL be synthesised.

Verification
REQ-027 Lock: after reset, feed valid words FFFFFFFF, 7FFFFFFF, 3FFFFFFF, 9FFFFFFF, then next() thereafter (LOCK_COUNT=4) -> LOCKED=1 exactly one cycle after the 5th valid word; ERR_COUNT=0.
REQ-028 Single error: while locked, flip bit 3 of one word -> one ERR_PULSE, ERR_COUNT=1, LOCKED stays 1, and the following correct words give no further pulses.
REQ-029 Loss of lock: while locked, send 3 consecutive wrong words (UNLOCK_COUNT=3) -> ERR_COUNT +3, LOCKED=0 one cycle after the 3rd; a correct stream then relocks after 5 valid words.
REQ-030 Edge cases: all-zero words in SEARCH keep LOCKED=0; IN_VALID gaps of 10 cycles mid-stream leave state unchanged; a mismatch in LOCKING causes a reseed with no ERR_PULSE.
REQ-031 Counters: CLR_ERR with a simultaneous error -> ERR_COUNT=0 and ERR_PULSE=1; with ERR_W=4 and 20 errors -> ERR_COUNT=15.
REQ-032 Macro: with LFSR_CHECKER_BITERR_EN, one locked word with 5 bits flipped -> BIT_ERR_COUNT=5; without the macro -> BIT_ERR_COUNT=0; RESETH asserted mid-lock -> all outputs 0 next cycle.

Source files
------------

// File: rtl/lfsr_checker.sv
// PRBS-32 lock/error checker: seeds from the received stream, flywheels once locked,
// counts word errors. Define LFSR_CHECKER_BITERR_EN to also count bit errors.
module lfsr_checker #(
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned UNLOCK_COUNT = 3,
  parameter int unsigned ERR_W        = 16
) (
  input  logic             CLK,
  input  logic             RESETH,
  input  logic             IN_VALID,
  input  logic [31:0]      IN_DATA,
  input  logic             CLR_ERR,
  output logic             LOCKED,
  output logic             ERR_PULSE,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [ERR_W-1:0] BIT_ERR_COUNT
);

  typedef enum logic [1:0] {ST_SEARCH, ST_LOCKING, ST_LOCKED} state_t;

  localparam logic [3:0] LOCK_CNT   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_CNT = 4'(UNLOCK_COUNT);

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[0] ^ s[9] ^ s[29] ^ s[30], s[31:1]};
  endfunction

  state_t           state;
  logic [31:0]      pred;
  logic [3:0]       match_cnt;
  logic [3:0]       miss_cnt;
  logic             mismatch;
  logic [ERR_W-1:0] err_count_inc;

  assign mismatch      = (IN_DATA != pred);
  assign err_count_inc = (&ERR_COUNT) ? ERR_COUNT : ERR_COUNT + ERR_W'(1);

  always_ff @(posedge CLK) begin
    if (RESETH) begin
      state     <= ST_SEARCH;
      LOCKED    <= 1'b0;
      ERR_PULSE <= 1'b0;
      ERR_COUNT <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      pred      <= '1;
    end else begin
      // NOTE: non-blocking assignments let a later statement override an earlier
      // one in the same block; the trailing CLR_ERR relies on that to win.
      ERR_PULSE <= 1'b0;
      if (IN_VALID) begin
        unique case (state)
          ST_SEARCH, ST_LOCKING: begin
            if (state == ST_LOCKING && !mismatch) begin
              match_cnt <= match_cnt + 4'd1;
              pred      <= lfsr_next(IN_DATA);
              if (match_cnt + 4'd1 == LOCK_CNT) begin
                state  <= ST_LOCKED;
                LOCKED <= 1'b1;
              end
            end else if (IN_DATA != '0) begin
              pred      <= lfsr_next(IN_DATA);
              match_cnt <= '0;
              state     <= ST_LOCKING;
            end else begin
              state <= ST_SEARCH;
            end
          end
          ST_LOCKED: begin
            // Flywheel: prediction never follows the received data while locked.
            pred <= lfsr_next(pred);
            if (mismatch) begin
              ERR_PULSE <= 1'b1;
              ERR_COUNT <= err_count_inc;
              if (miss_cnt + 4'd1 == UNLOCK_CNT) begin
                miss_cnt <= '0;
                state    <= ST_SEARCH;
                LOCKED   <= 1'b0;
              end else begin
                miss_cnt <= miss_cnt + 4'd1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: state <= ST_SEARCH;
        endcase
      end
      if (CLR_ERR) ERR_COUNT <= '0;
    end
  end

`ifdef LFSR_CHECKER_BITERR_EN
  localparam int unsigned SUM_W = ((ERR_W > 6) ? ERR_W : 6) + 1;

  logic [5:0]       pop;
  logic [SUM_W-1:0] bit_sum;
  logic [ERR_W-1:0] bit_err_next;

  always_comb begin
    pop          = 6'($countones(IN_DATA ^ pred));
    bit_sum      = SUM_W'(BIT_ERR_COUNT) + SUM_W'(pop);
    bit_err_next = BIT_ERR_COUNT;
    if (bit_sum > SUM_W'({ERR_W{1'b1}})) bit_err_next = '1;
    else                                 bit_err_next = bit_sum[ERR_W-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RESETH) begin
      BIT_ERR_COUNT <= '0;
    end else begin
      if (IN_VALID && state == ST_LOCKED && mismatch) BIT_ERR_COUNT <= bit_err_next;
      if (CLR_ERR) BIT_ERR_COUNT <= '0;
    end
  end
`else
  assign BIT_ERR_COUNT = '0;
`endif

endmodule
